ahb_lite_mem_slave: RTL and testbench

AHB_LITE_MEM_SLAVE -- requirements
Module: ahb_lite_mem_slave

---
 rtl/ahb_lite_mem_slave.sv | 181 ++++++++++++++++++
 tb/tb_ahb_lite_mem_slave.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_lite_mem_slave.sv
// AHB-Lite memory slave: MEM_DEPTH_WORDS x 32-bit word store with byte/half/word
// access, two-cycle ERROR response for illegal transfers and read-after-write
// forwarding. Optional macro AHB_MEM_WAIT_STATE_EN adds one wait cycle per legal
// transfer.
module ahb_lite_mem_slave #(
  parameter int unsigned MEM_DEPTH_WORDS = 64
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [7:0]  HADDR,
  input  logic [31:0] HWDATA,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [3:0]  HPROT,
  input  logic [1:0]  HTRANS,
  input  logic        HMASTLOCK,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic [31:0] HRDATA
);

  localparam int unsigned AW         = (MEM_DEPTH_WORDS > 1) ? $clog2(MEM_DEPTH_WORDS) : 1;
  localparam logic [8:0]  BYTE_LIMIT = 9'(4 * MEM_DEPTH_WORDS);

  typedef enum logic [2:0] {
    IDLE,
    DATA,
    ERR1,
    ERR2
`ifdef AHB_MEM_WAIT_STATE_EN
    , WAIT
`endif
  } state_t;

  state_t state, next_state;

  logic [31:0]   mem [MEM_DEPTH_WORDS];

  logic          accept;
  logic          legal;
  logic          align_ok;
  logic [3:0]    be_in;
  logic [AW-1:0] word_in;

  logic          ap_write;
  logic [3:0]    ap_be;
  logic [AW-1:0] ap_word;

  logic          wr_commit;
  logic [31:0]   rd_word;

  // Burst type, protection and lock carry no meaning for this memory.
  logic unused_ok;
  assign unused_ok = ^{HBURST, HPROT, HMASTLOCK, HADDR};

  assign word_in = HADDR[AW+1:2];

  // Address-phase decode: acceptance, legality and byte-lane enables.
  always_comb begin
    accept   = HSEL & HREADY & HTRANS[1];
    be_in    = '0;
    align_ok = 1'b0;
    case (HSIZE)
      3'd0: begin
        be_in    = 4'b0001 << HADDR[1:0];
        align_ok = 1'b1;
      end
      3'd1: begin
        be_in    = HADDR[1] ? 4'b1100 : 4'b0011;
        align_ok = ~HADDR[0];
      end
      3'd2: begin
        be_in    = '1;
        align_ok = (HADDR[1:0] == 2'b00);
      end
      default: begin
        be_in    = '0;
        align_ok = 1'b0;
      end
    endcase
    legal = align_ok & ({1'b0, HADDR} < BYTE_LIMIT);
  end

  // Register the address phase whenever the bus advances; held across stalls.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      ap_write <= 1'b0;
      ap_be    <= '0;
      ap_word  <= '0;
    end else if (HREADY) begin
      ap_write <= accept & legal & HWRITE;
      ap_be    <= be_in;
      ap_word  <= word_in;
    end
  end

  // Writes land at the edge that ends the DATA cycle; reset clears state to
  // IDLE so a pending write is dropped.
  assign wr_commit = (state == DATA) && ap_write;

  // Memory array: byte-lane write, contents survive reset.
  always_ff @(posedge HCLK) begin
    if (wr_commit) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (ap_be[i]) begin
          mem[ap_word][8*i +: 8] <= HWDATA[8*i +: 8];
        end
      end
    end
  end

  // Read word with forwarding of bytes being committed by a write in its DATA cycle.
  always_comb begin
    rd_word = mem[word_in];
    for (int unsigned i = 0; i < 4; i++) begin
      if (wr_commit && (ap_word == word_in) && ap_be[i]) begin
        rd_word[8*i +: 8] = HWDATA[8*i +: 8];
      end
    end
  end

  // Read data captured at read acceptance and held until the next legal read.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      HRDATA <= '0;
    end else if (accept & legal & ~HWRITE) begin
      HRDATA <= rd_word;
    end
  end

  // FSM state register.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and response outputs.
  always_comb begin
    next_state = IDLE;
    HREADYOUT  = 1'b1;
    HRESP      = 1'b0;
    case (state)
      ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = 1'b1;
      end
      ERR2: begin
        HRESP = 1'b1;
      end
`ifdef AHB_MEM_WAIT_STATE_EN
      WAIT: begin
        HREADYOUT = 1'b0;
      end
`endif
      default: begin
      end
    endcase

    if (state == ERR1) begin
      next_state = ERR2;
    end
`ifdef AHB_MEM_WAIT_STATE_EN
    else if (state == WAIT) begin
      next_state = DATA;
    end else if (accept) begin
      next_state = legal ? WAIT : ERR1;
    end
`else
    else if (accept) begin
      next_state = legal ? DATA : ERR1;
    end
`endif
  end

endmodule

// File: tb/tb_ahb_lite_mem_slave.sv
// Self-checking bench for ahb_lite_mem_slave: directed vector table, reset and
// burst sequences, and randomized transfers against a byte-array reference model.
module tb_ahb_lite_mem_slave;

`ifdef AHB_MEM_WAIT_STATE_EN
  localparam int WS = 1;
`else
  localparam int WS = 0;
`endif
  localparam int DEPTH = 64;

  logic        HCLK;
  logic        HRESETn;
  logic        HSEL;
  logic [7:0]  HADDR;
  logic [31:0] HWDATA;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic [1:0]  HTRANS;
  logic        HMASTLOCK;
  logic        HREADY;
  logic        HREADYOUT;
  logic        HRESP;
  logic [31:0] HRDATA;

  assign HREADY = HREADYOUT;

  ahb_lite_mem_slave #(.MEM_DEPTH_WORDS(DEPTH)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR),
    .HWDATA(HWDATA), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
    .HPROT(HPROT), .HTRANS(HTRANS), .HMASTLOCK(HMASTLOCK), .HREADY(HREADY),
    .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA)
  );

  initial begin
    HCLK = 1'b0;
    forever #5 HCLK = ~HCLK;
  end

  typedef struct {
    logic        sel;
    logic [1:0]  trans;
    logic        wr;
    logic [2:0]  size;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rd;
  } beat_t;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  mbytes [256];
  logic [31:0] last_rd = '0;
  beat_t       q [$];
  int          last_cycles;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: sequential byte-addressed memory, transfers in issue order.
  task automatic model_step(input beat_t b, output logic err, output logic [31:0] rd);
    int a;
    int base;
    err = 1'b0;
    rd  = '0;
    if (!(b.sel && b.trans[1])) return;
    a = int'(b.addr);
    if (b.size > 3'd2 || (a % (1 << b.size)) != 0 || a >= 4 * DEPTH) begin
      err = 1'b1;
      return;
    end
    base = a - (a % 4);
    if (b.wr) begin
      for (int k = 0; k < (1 << b.size); k++)
        mbytes[a + k] = b.wdata[8 * ((a + k) % 4) +: 8];
    end else begin
      rd = {mbytes[base + 3], mbytes[base + 2], mbytes[base + 1], mbytes[base]};
    end
  endtask

  task automatic drive_idle();
    HSEL   = 1'b0;
    HTRANS = 2'd0;
    HWRITE = 1'b0;
    HSIZE  = 3'd0;
    HADDR  = 8'($urandom_range(255));
  endtask

  // Pipelined driver/checker for the beats in q.
  task automatic run_seq(input string tag);
    int    idx;
    int    n;
    int    c;
    int    len;
    int    cycles;
    bit    dv;
    bit    xfer;
    logic  rdy;
    logic  er;
    logic  ep;
    logic [31:0] erd;
    beat_t d;
    idx = 0; n = q.size(); c = 0; cycles = 0; dv = 0;
    d = '{default: '0};
    @(posedge HCLK); #1;
    while (idx < n || dv) begin
      if (idx < n) begin
        HSEL   = q[idx].sel;
        HTRANS = q[idx].trans;
        HWRITE = q[idx].wr;
        HSIZE  = q[idx].size;
        HADDR  = q[idx].addr;
      end else begin
        drive_idle();
      end
      HWDATA = (dv && d.wr) ? d.wdata : $urandom;
      @(negedge HCLK);
      cycles++;
      xfer = dv && d.sel && d.trans[1];
      if (!xfer) begin
        len = 1; er = 1'b1; ep = 1'b0;
      end else if (d.exp_err) begin
        len = 2; er = (c == 1); ep = 1'b1;
      end else begin
        len = 1 + WS; er = (c == len - 1); ep = 1'b0;
      end
      erd = (xfer && !d.exp_err && !d.wr) ? d.exp_rd : last_rd;
      chk($sformatf("%s[%0d] hreadyout c%0d", tag, idx - 1, c), HREADYOUT, er);
      chk($sformatf("%s[%0d] hresp c%0d", tag, idx - 1, c), HRESP, ep);
      chk($sformatf("%s[%0d] hrdata c%0d", tag, idx - 1, c), HRDATA, erd);
      rdy = HREADYOUT;
      @(posedge HCLK); #1;
      if (rdy || c >= len + 1) begin
        if (!rdy) begin
          checks++;
          errors++;
          $display("FAIL %s[%0d] data phase timeout: got no HREADYOUT expected 1", tag, idx - 1);
        end
        if (xfer && !d.exp_err && !d.wr) last_rd = d.exp_rd;
        if (idx < n) begin
          d = q[idx];
          idx++;
          dv = 1;
        end else begin
          dv = 0;
        end
        c = 0;
      end else begin
        c++;
      end
    end
    q.delete();
    last_cycles = cycles;
  endtask

  task automatic push_model(input beat_t b);
    beat_t t;
    t = b;
    model_step(t, t.exp_err, t.exp_rd);
    q.push_back(t);
  endtask

  localparam logic [1:0] ID = 2'd0, BS = 2'd1, NS = 2'd2, SQ = 2'd3;

  beat_t tbl [21];

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    beat_t b;
    logic  e;
    logic [31:0] r;

    // Directed vectors: {sel, trans, wr, size, addr, wdata, exp_err, exp_rd}
    tbl = '{
      '{1'b1, NS, 1'b1, 3'd2, 8'h00, 32'h0BADF00D, 1'b0, 32'h0},
      '{1'b1, NS, 1'b1, 3'd2, 8'h10, 32'hDEADBEEF, 1'b0, 32'h0},
      '{1'b1, NS, 1'b0, 3'd2, 8'h10, 32'h0,        1'b0, 32'hDEADBEEF},
      '{1'b0, NS, 1'b1, 3'd2, 8'h10, 32'hFFFFFFFF, 1'b0, 32'h0},
      '{1'b1, NS, 1'b0, 3'd2, 8'h10, 32'h0,        1'b0, 32'hDEADBEEF},
      '{1'b1, NS, 1'b1, 3'd2, 8'h10, 32'h11223344, 1'b0, 32'h0},
      '{1'b1, ID, 1'b1, 3'd2, 8'h10, 32'h0,        1'b0, 32'h0},
      '{1'b1, NS, 1'b1, 3'd0, 8'h13, 32'hAA000000, 1'b0, 32'h0},
      '{1'b1, NS, 1'b0, 3'd2, 8'h10, 32'h0,        1'b0, 32'hAA223344},
      '{1'b1, NS, 1'b1, 3'd2, 8'h02, 32'hFFFFFFFF, 1'b1, 32'h0},
      '{1'b1, NS, 1'b0, 3'd2, 8'h02, 32'h0,        1'b1, 32'h0},
      '{1'b1, NS, 1'b0, 3'd2, 8'h00, 32'h0,        1'b0, 32'h0BADF00D},
      '{1'b1, NS, 1'b1, 3'd2, 8'h20, 32'h55667788, 1'b0, 32'h0},
      '{1'b1, SQ, 1'b0, 3'd2, 8'h20, 32'h0,        1'b0, 32'h55667788},
      '{1'b1, NS, 1'b1, 3'd1, 8'h21, 32'h00AB0000, 1'b1, 32'h0},
      '{1'b1, NS, 1'b1, 3'd1, 8'h22, 32'hBEEF0000, 1'b0, 32'h0},
      '{1'b1, NS, 1'b0, 3'd0, 8'h21, 32'h0,        1'b0, 32'hBEEF7788},
      '{1'b1, NS, 1'b0, 3'd3, 8'h24, 32'h0,        1'b1, 32'h0},
      '{1'b1, BS, 1'b1, 3'd2, 8'h20, 32'h0,        1'b0, 32'h0},
      '{1'b1, NS, 1'b0, 3'd1, 8'h22, 32'h0,        1'b0, 32'hBEEF7788},
      '{1'b1, NS, 1'b0, 3'd2, 8'hFC, 32'h0,        1'b0, 32'h0}
    };

    HBURST = 3'd0; HPROT = 4'd3; HMASTLOCK = 1'b0; HWDATA = '0;
    drive_idle();
    HRESETn = 1'b0;
    #1;
    chk("reset hreadyout", HREADYOUT, 1'b1);
    chk("reset hresp", HRESP, 1'b0);
    chk("reset hrdata", HRDATA, 32'h0);
    repeat (2) @(posedge HCLK);
    @(negedge HCLK);
    HRESETn = 1'b1;

    // Fill every word back-to-back; also measures sustained throughput.
    for (int w = 0; w < DEPTH; w++) begin
      b = '{1'b1, (w == 0) ? NS : SQ, 1'b1, 3'd2, 8'(4 * w), $urandom, 1'b0, 32'h0};
      push_model(b);
    end
    run_seq("init");
    chk("init throughput cycles", 32'(last_cycles), 32'(DEPTH * (1 + WS) + 1));

    for (int i = 0; i < 21; i++) begin
      model_step(tbl[i], e, r);
      q.push_back(tbl[i]);
    end
    // The last row reads a word written only by the fill sequence; take it from the model.
    q[20].exp_rd = r;
    run_seq("tbl");

    // Four-beat incrementing word read burst from 0x00.
    for (int k = 0; k < 4; k++) begin
      b = '{1'b1, (k == 0) ? NS : SQ, 1'b0, 3'd2, 8'(4 * k), 32'h0, 1'b0, 32'h0};
      push_model(b);
    end
    HBURST = 3'd3;
    run_seq("burst");
    chk("burst cycles", 32'(last_cycles), 32'(4 * (1 + WS) + 1));
    HBURST = 3'd0;

    // Reset during the data phase of a write discards it.
    @(posedge HCLK); #1;
    HSEL = 1'b1; HTRANS = NS; HWRITE = 1'b1; HSIZE = 3'd2; HADDR = 8'h30;
    @(posedge HCLK); #1;
    for (int s = 0; s < WS; s++) begin
      @(posedge HCLK); #1;
    end
    drive_idle();
    HWDATA = 32'h12345678;
    #2;
    HRESETn = 1'b0;
    #1;
    chk("midreset hreadyout", HREADYOUT, 1'b1);
    chk("midreset hresp", HRESP, 1'b0);
    chk("midreset hrdata", HRDATA, 32'h0);
    last_rd = '0;
    @(posedge HCLK);
    @(negedge HCLK);
    HRESETn = 1'b1;
    b = '{1'b1, NS, 1'b0, 3'd2, 8'h30, 32'h0, 1'b0, 32'h0};
    push_model(b);
    b = '{1'b1, NS, 1'b0, 3'd0, 8'h33, 32'h0, 1'b0, 32'h0};
    push_model(b);
    run_seq("postreset");

    // Randomized transfers against the model.
    for (int k = 0; k < 300; k++) begin
      b.sel   = ($urandom_range(9) != 0);
      b.trans = 2'($urandom_range(3));
      b.wr    = 1'($urandom_range(1));
      b.size  = ($urandom_range(15) == 0) ? 3'($urandom_range(7, 3)) : 3'($urandom_range(2));
      b.addr  = 8'($urandom_range(255));
      if (b.size <= 3'd2 && $urandom_range(3) != 0)
        b.addr = b.addr - 8'(int'(b.addr) % (1 << b.size));
      b.wdata = $urandom;
      push_model(b);
    end
    run_seq("rand");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
